// File: rtl/uart_duplex.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_duplex
// Brief    : 8-bit UART transmitter looped back into a 16x-oversampling UART
//            receiver, with parity generation/checking and frame error flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_duplex #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       send,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    input  logic [7:0] data_in,
    output logic       tx_active_flag,
    output logic       tx_done_flag,
    output logic       rx_active_flag,
    output logic       rx_done_flag,
    output logic [2:0] error_flag,
    output logic [7:0] data_out
);

    localparam int c_TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(OVERSAMPLE - 1);
    localparam logic [c_TW-1:0] c_TICK_MID  = c_TW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TW-1:0] c_TICK_ONE  = c_TW'(1);

    localparam logic [15:0] c_DIV_2400  = 16'((CLK_FREQ + (2400  * OVERSAMPLE) / 2) / (2400  * OVERSAMPLE));
    localparam logic [15:0] c_DIV_4800  = 16'((CLK_FREQ + (4800  * OVERSAMPLE) / 2) / (4800  * OVERSAMPLE));
    localparam logic [15:0] c_DIV_9600  = 16'((CLK_FREQ + (9600  * OVERSAMPLE) / 2) / (9600  * OVERSAMPLE));
    localparam logic [15:0] c_DIV_19200 = 16'((CLK_FREQ + (19200 * OVERSAMPLE) / 2) / (19200 * OVERSAMPLE));

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // Frame settings latched at TX start, shared by both directions
    logic [15:0]     r_div;
    logic [1:0]      r_par_type;
    logic [7:0]      r_tx_data;

    logic [2:0]      r_tx_state;
    logic [15:0]     r_tx_baud;
    logic [c_TW-1:0] r_tx_tick;
    logic [2:0]      r_tx_bit;
    logic            r_tx_line;
    logic            r_tx_active;
    logic            r_tx_done;

    logic [2:0]      r_rx_state;
    logic [15:0]     r_rx_baud;
    logic [c_TW-1:0] r_rx_tick;
    logic [2:0]      r_rx_bit;
    logic [7:0]      r_rx_shift;
    logic            r_rx_line_d;
    logic            r_rx_active;
    logic            r_rx_done;
    logic [2:0]      r_err;
    logic [7:0]      r_data_out;

    logic [15:0]     w_div_sel;
    logic [15:0]     w_div_last;
    logic            w_tx_tick;
    logic            w_rx_tick;
    logic            w_line;
    logic            w_tx_par;
    logic            w_tx_bit_val;
    logic            w_tx_next_val;
    logic            w_rx_par_exp;
    logic            w_par_chk;

    assign w_line     = r_tx_line;
    assign w_div_last = r_div - 16'd1;
    assign w_tx_tick  = (r_tx_baud == w_div_last);
    assign w_rx_tick  = (r_rx_baud == w_div_last);
    assign w_par_chk  = (r_par_type == 2'b01) || (r_par_type == 2'b10);
    assign w_rx_par_exp = (r_par_type == 2'b01) ? ~^r_rx_shift : ^r_rx_shift;

    always_comb begin
        w_div_sel = c_DIV_2400;
        case (baud_rate)
            2'b00:   w_div_sel = c_DIV_2400;
            2'b01:   w_div_sel = c_DIV_4800;
            2'b10:   w_div_sel = c_DIV_9600;
            default: w_div_sel = c_DIV_19200;
        endcase
    end

    always_comb begin
        w_tx_par = 1'b1;
        case (r_par_type)
            2'b01:   w_tx_par = ~^r_tx_data;
            2'b10:   w_tx_par = ^r_tx_data;
            default: w_tx_par = 1'b1;
        endcase
    end

    // Level of the bit being sent now, and of the bit that follows it
    always_comb begin
        w_tx_bit_val  = 1'b1;
        w_tx_next_val = 1'b1;
        case (r_tx_state)
            c_ST_START: begin
                w_tx_bit_val  = 1'b0;
                w_tx_next_val = r_tx_data[0];
            end
            c_ST_DATA: begin
                w_tx_bit_val  = r_tx_data[r_tx_bit];
                w_tx_next_val = (r_tx_bit == 3'd7) ? w_tx_par : r_tx_data[r_tx_bit + 3'd1];
            end
            c_ST_PARITY: begin
                w_tx_bit_val  = w_tx_par;
                w_tx_next_val = 1'b1;
            end
            default: begin
                w_tx_bit_val  = 1'b1;
                w_tx_next_val = 1'b1;
            end
        endcase
    end

    // reset_n is active-high despite its name
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            r_div       <= c_DIV_2400;
            r_par_type  <= 2'b00;
            r_tx_data   <= 8'h00;
            r_tx_state  <= c_ST_IDLE;
            r_tx_baud   <= '0;
            r_tx_tick   <= '0;
            r_tx_bit    <= '0;
            r_tx_line   <= 1'b1;
            r_tx_active <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            case (r_tx_state)
                c_ST_IDLE: begin
                    r_tx_line <= 1'b1;
                    if (send) begin
                        r_tx_state  <= c_ST_START;
                        r_div       <= w_div_sel;
                        r_par_type  <= parity_type;
                        r_tx_data   <= data_in;
                        r_tx_baud   <= '0;
                        r_tx_tick   <= '0;
                        r_tx_bit    <= '0;
                        r_tx_line   <= 1'b0;
                        r_tx_active <= 1'b1;
                        r_tx_done   <= 1'b0;
                    end
                end
                default: begin
                    r_tx_baud <= w_tx_tick ? 16'd0 : r_tx_baud + 16'd1;
                    r_tx_line <= w_tx_bit_val;
                    if (w_tx_tick) begin
                        if (r_tx_tick == c_TICK_LAST) begin
                            r_tx_tick <= '0;
                            r_tx_line <= w_tx_next_val;
                            case (r_tx_state)
                                c_ST_START: begin
                                    r_tx_state <= c_ST_DATA;
                                    r_tx_bit   <= '0;
                                end
                                c_ST_DATA: begin
                                    if (r_tx_bit == 3'd7) begin
                                        r_tx_state <= c_ST_PARITY;
                                    end else begin
                                        r_tx_bit <= r_tx_bit + 3'd1;
                                    end
                                end
                                c_ST_PARITY: begin
                                    r_tx_state <= c_ST_STOP;
                                end
                                default: begin
                                    r_tx_state  <= c_ST_IDLE;
                                    r_tx_active <= 1'b0;
                                    r_tx_done   <= 1'b1;
                                end
                            endcase
                        end else begin
                            r_tx_tick <= r_tx_tick + c_TICK_ONE;
                        end
                    end
                end
            endcase
        end
    end

    // Receiver runs its own baud counter, phased to the detected start edge
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            r_rx_state  <= c_ST_IDLE;
            r_rx_baud   <= '0;
            r_rx_tick   <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= 8'h00;
            r_rx_line_d <= 1'b1;
            r_rx_active <= 1'b0;
            r_rx_done   <= 1'b0;
            r_err       <= 3'b000;
            r_data_out  <= 8'h00;
        end else begin
            r_rx_line_d <= w_line;
            case (r_rx_state)
                c_ST_IDLE: begin
                    if (r_rx_line_d && !w_line) begin
                        r_rx_state  <= c_ST_START;
                        r_rx_baud   <= '0;
                        r_rx_tick   <= '0;
                        r_rx_bit    <= '0;
                        r_rx_active <= 1'b1;
                        r_rx_done   <= 1'b0;
                        r_err       <= 3'b000;
                    end
                end
                c_ST_START: begin
                    r_rx_baud <= w_rx_tick ? 16'd0 : r_rx_baud + 16'd1;
                    if (w_rx_tick) begin
                        if (r_rx_tick == c_TICK_MID) begin
                            r_rx_tick <= '0;
                            if (w_line) begin
                                r_err[1]    <= 1'b1;
                                r_rx_state  <= c_ST_IDLE;
                                r_rx_active <= 1'b0;
                            end else begin
                                r_rx_state <= c_ST_DATA;
                            end
                        end else begin
                            r_rx_tick <= r_rx_tick + c_TICK_ONE;
                        end
                    end
                end
                default: begin
                    r_rx_baud <= w_rx_tick ? 16'd0 : r_rx_baud + 16'd1;
                    if (w_rx_tick) begin
                        if (r_rx_tick == c_TICK_LAST) begin
                            r_rx_tick <= '0;
                            case (r_rx_state)
                                c_ST_DATA: begin
                                    r_rx_shift <= {w_line, r_rx_shift[7:1]};
                                    r_rx_bit   <= r_rx_bit + 3'd1;
                                    if (r_rx_bit == 3'd7) begin
                                        r_rx_state <= c_ST_PARITY;
                                    end
                                end
                                c_ST_PARITY: begin
                                    if (w_par_chk && (w_line != w_rx_par_exp)) begin
                                        r_err[0] <= 1'b1;
                                    end
                                    r_rx_state <= c_ST_STOP;
                                end
                                default: begin
                                    r_err[2]    <= ~w_line;
                                    r_data_out  <= r_rx_shift;
                                    r_rx_done   <= 1'b1;
                                    r_rx_active <= 1'b0;
                                    r_rx_state  <= c_ST_IDLE;
                                end
                            endcase
                        end else begin
                            r_rx_tick <= r_rx_tick + c_TICK_ONE;
                        end
                    end
                end
            endcase
        end
    end

    assign tx_active_flag = r_tx_active;
    assign tx_done_flag   = r_tx_done;
    assign rx_active_flag = r_rx_active;
    assign rx_done_flag   = r_rx_done;
    assign error_flag     = r_err;
    assign data_out       = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_uart_duplex.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_duplex
// Brief    : Directed scoreboard bench for the uart_duplex loopback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_duplex;

    // Small clock so the baud divisors come out as 32/16/8/4
    localparam int CLK_FREQ = 1_228_800;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       send;
    logic [1:0] parity_type;
    logic [1:0] baud_rate;
    logic [7:0] data_in;
    logic       tx_active_flag;
    logic       tx_done_flag;
    logic       rx_active_flag;
    logic       rx_done_flag;
    logic [2:0] error_flag;
    logic [7:0] data_out;

    int          n_vec = 0;
    int          n_err = 0;
    logic [10:0] sb_q[$];

    uart_duplex #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (16)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .send           (send),
        .parity_type    (parity_type),
        .baud_rate      (baud_rate),
        .data_in        (data_in),
        .tx_active_flag (tx_active_flag),
        .tx_done_flag   (tx_done_flag),
        .rx_active_flag (rx_active_flag),
        .rx_done_flag   (rx_done_flag),
        .error_flag     (error_flag),
        .data_out       (data_out)
    );

    always #5 clock = ~clock;

    function automatic int div_of(input logic [1:0] br);
        case (br)
            2'b00:   return 32;
            2'b01:   return 16;
            2'b10:   return 8;
            default: return 4;
        endcase
    endfunction

    function automatic logic par_of(input logic [1:0] pt, input logic [7:0] d);
        case (pt)
            2'b01:   return ~^d;
            2'b10:   return ^d;
            default: return 1'b1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame request; returns #1 after the edge that starts the frame
    task automatic start_frame(input logic [1:0] br, input logic [1:0] pt, input logic [7:0] d,
                               input logic [2:0] err, input bit hold, input bit push);
        baud_rate   = br;
        parity_type = pt;
        data_in     = d;
        send        = 1'b1;
        if (push) sb_q.push_back({err, d});
        @(posedge clock);
        #1;
        if (!hold) send = 1'b0;
    endtask

    // Follows a frame to tx_done, scoring the received byte when rx_done rises
    task automatic run_frame(input logic [1:0] br, input logic [1:0] pt, input logic [7:0] d,
                             input int force_at, input int cyc0);
        int          cyc;
        int          budget;
        int          rx_seen;
        logic        rx_prev;
        logic        par_bit;
        logic [10:0] exp;
        bit          forced;
        cyc     = cyc0;
        budget  = 176 * div_of(br) + 64;
        rx_seen = 0;
        rx_prev = rx_done_flag;
        par_bit = 1'bx;
        forced  = 1'b0;
        while (tx_done_flag !== 1'b1 && cyc < budget) begin
            @(posedge clock);
            #1;
            cyc++;
            if (force_at != 0 && cyc == force_at) begin
                force dut.r_tx_line = 1'b0;
                forced = 1'b1;
            end
            if (cyc == 152 * div_of(br)) par_bit = dut.r_tx_line;
            if (rx_done_flag === 1'b1 && rx_prev !== 1'b1) begin
                rx_seen++;
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    check("rx_data", 32'(data_out), 32'(exp[7:0]));
                    check("rx_error", 32'(error_flag), 32'(exp[10:8]));
                    check("rx_active_off", 32'(rx_active_flag), 32'd0);
                end
                if (forced) begin
                    release dut.r_tx_line;
                    forced = 1'b0;
                end
            end
            rx_prev = rx_done_flag;
        end
        if (forced) release dut.r_tx_line;
        check("tx_frame_cycles", 32'(cyc), 32'(176 * div_of(br)));
        check("rx_frames_seen", 32'(rx_seen), 32'd1);
        if (force_at == 0) check("tx_parity_bit", 32'(par_bit), 32'(par_of(pt, d)));
    endtask

    initial begin
        reset_n     = 1'b1;
        send        = 1'b0;
        parity_type = 2'b00;
        baud_rate   = 2'b00;
        data_in     = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("rst_tx_active", 32'(tx_active_flag), 32'd0);
        check("rst_tx_done", 32'(tx_done_flag), 32'd0);
        check("rst_rx_active", 32'(rx_active_flag), 32'd0);
        check("rst_rx_done", 32'(rx_done_flag), 32'd0);
        check("rst_error", 32'(error_flag), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_line", 32'(dut.r_tx_line), 32'd1);
        reset_n = 1'b0;
        @(posedge clock);
        #1;

        // 9600 baud, odd parity
        start_frame(2'b10, 2'b01, 8'hAA, 3'b000, 1'b0, 1'b1);
        check("start_tx_active", 32'(tx_active_flag), 32'd1);
        check("start_tx_done", 32'(tx_done_flag), 32'd0);
        run_frame(2'b10, 2'b01, 8'hAA, 0, 0);
        check("end_tx_active", 32'(tx_active_flag), 32'd0);

        // 19200 baud, even parity; live settings changed mid-frame must not matter
        start_frame(2'b11, 2'b10, 8'h5C, 3'b000, 1'b0, 1'b1);
        baud_rate   = 2'b00;
        parity_type = 2'b01;
        data_in     = 8'h11;
        run_frame(2'b11, 2'b10, 8'h5C, 0, 0);

        // No-parity encodings, extreme data
        start_frame(2'b10, 2'b00, 8'h00, 3'b000, 1'b0, 1'b1);
        run_frame(2'b10, 2'b00, 8'h00, 0, 0);
        start_frame(2'b10, 2'b11, 8'hFF, 3'b000, 1'b0, 1'b1);
        run_frame(2'b10, 2'b11, 8'hFF, 0, 0);
        start_frame(2'b01, 2'b01, 8'h37, 3'b000, 1'b0, 1'b1);
        run_frame(2'b01, 2'b01, 8'h37, 0, 0);

        // Back-to-back frames with data changed during the first
        start_frame(2'b10, 2'b01, 8'h3C, 3'b000, 1'b1, 1'b1);
        data_in = 8'hC3;
        sb_q.push_back({3'b000, 8'hC3});
        run_frame(2'b10, 2'b01, 8'h3C, 0, 0);
        check("b2b_done_high", 32'(tx_done_flag), 32'd1);
        @(posedge clock);
        #1;
        check("b2b_done_pulse", 32'(tx_done_flag), 32'd0);
        check("b2b_restart", 32'(tx_active_flag), 32'd1);
        send = 1'b0;
        run_frame(2'b10, 2'b01, 8'hC3, 0, 0);

        // Reset in the middle of a frame
        start_frame(2'b10, 2'b01, 8'h81, 3'b000, 1'b0, 1'b0);
        repeat (600) @(posedge clock);
        #3;
        reset_n = 1'b1;
        #1;
        check("midrst_tx_active", 32'(tx_active_flag), 32'd0);
        check("midrst_rx_active", 32'(rx_active_flag), 32'd0);
        check("midrst_tx_done", 32'(tx_done_flag), 32'd0);
        check("midrst_rx_done", 32'(rx_done_flag), 32'd0);
        check("midrst_data_out", 32'(data_out), 32'd0);
        check("midrst_line", 32'(dut.r_tx_line), 32'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        start_frame(2'b10, 2'b10, 8'h96, 3'b000, 1'b0, 1'b1);
        run_frame(2'b10, 2'b10, 8'h96, 0, 0);

        // Line held low over parity (expected 1) and stop bit
        start_frame(2'b10, 2'b01, 8'h00, 3'b101, 1'b0, 1'b1);
        run_frame(2'b10, 2'b01, 8'h00, 1160, 0);
        check("err_held", 32'(error_flag), 32'd5);

        // Next start bit clears the error flags
        start_frame(2'b11, 2'b00, 8'h7E, 3'b000, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        check("err_cleared", 32'(error_flag), 32'd0);
        check("rx_active_on", 32'(rx_active_flag), 32'd1);
        check("rx_done_cleared", 32'(rx_done_flag), 32'd0);
        run_frame(2'b11, 2'b00, 8'h7E, 0, 1);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
